// File: rtl/conv_8_4_host.sv
// Host-side sequencer for a 1-D convolution block: buffers x/f samples, streams them out,
// collects y results into a readback buffer.
module conv_8_4_host #(
    parameter int unsigned XLEN = 8,
    parameter int unsigned FLEN = 4,
    parameter int unsigned YLEN = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ld_en,
    input  logic               ld_sel,
    input  logic [2:0]         ld_addr,
    input  logic signed [7:0]  ld_data,
    input  logic               start,
    output logic signed [7:0]  m_data_x,
    output logic               m_valid_x,
    input  logic               m_ready_x,
    output logic signed [7:0]  m_data_f,
    output logic               m_valid_f,
    input  logic               m_ready_f,
    input  logic signed [17:0] s_data_y,
    input  logic               s_valid_y,
    output logic               s_ready_y,
    input  logic [2:0]         rd_addr,
    output logic signed [17:0] rd_data,
    output logic               busy,
    output logic               done
);

    localparam int unsigned CW  = $clog2(XLEN + 1);
    localparam int unsigned XAW = $clog2(XLEN);
    localparam int unsigned FAW = $clog2(FLEN);
    localparam int unsigned YAW = $clog2(YLEN);
    localparam logic [CW-1:0] XLIM = CW'(XLEN);
    localparam logic [CW-1:0] FLIM = CW'(FLEN);
    localparam logic [CW-1:0] YLIM = CW'(YLEN);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e                state_q;
    logic [CW-1:0]         x_cnt_q, f_cnt_q, y_cnt_q;
    logic [CW-1:0]         x_cnt_d, f_cnt_d, y_cnt_d;
    logic signed [7:0]     xbuf_q [XLEN];
    logic signed [7:0]     fbuf_q [FLEN];
    logic signed [17:0]    ybuf_q [YLEN];
    logic signed [17:0]    rd_data_q;
    logic                  x_fire, f_fire, y_fire, all_done;

    // Handshake-facing signals decode registered state only; no ready-to-valid path.
    assign m_valid_x = (state_q == RUN) && (x_cnt_q < XLIM);
    assign m_valid_f = (state_q == RUN) && (f_cnt_q < FLIM);
    assign s_ready_y = (state_q == RUN) && (y_cnt_q < YLIM);
    assign m_data_x  = (x_cnt_q < XLIM) ? xbuf_q[XAW'(x_cnt_q)] : '0;
    assign m_data_f  = (f_cnt_q < FLIM) ? fbuf_q[FAW'(f_cnt_q)] : '0;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign rd_data   = rd_data_q;

    assign x_fire = m_valid_x && m_ready_x;
    assign f_fire = m_valid_f && m_ready_f;
    assign y_fire = s_valid_y && s_ready_y;

    always_comb begin
        x_cnt_d = x_cnt_q;
        f_cnt_d = f_cnt_q;
        y_cnt_d = y_cnt_q;
        if (state_q == IDLE && start) begin
            x_cnt_d = '0;
            f_cnt_d = '0;
            y_cnt_d = '0;
        end else begin
            if (x_fire) x_cnt_d = x_cnt_q + CW'(1);
            if (f_fire) f_cnt_d = f_cnt_q + CW'(1);
            if (y_fire) y_cnt_d = y_cnt_q + CW'(1);
        end
    end

    // Next-cycle counts so simultaneous final transfers still end the run on that edge.
    assign all_done = (x_cnt_d == XLIM) && (f_cnt_d == FLIM) && (y_cnt_d == YLIM);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            x_cnt_q   <= '0;
            f_cnt_q   <= '0;
            y_cnt_q   <= '0;
            rd_data_q <= '0;
            for (int i = 0; i < int'(XLEN); i++) xbuf_q[i] <= '0;
            for (int i = 0; i < int'(FLEN); i++) fbuf_q[i] <= '0;
            for (int i = 0; i < int'(YLEN); i++) ybuf_q[i] <= '0;
        end else begin
            x_cnt_q <= x_cnt_d;
            f_cnt_q <= f_cnt_d;
            y_cnt_q <= y_cnt_d;
            case (state_q)
                IDLE: begin
                    if (ld_en) begin
                        if (!ld_sel && (32'(ld_addr) < XLEN))
                            xbuf_q[XAW'(ld_addr)] <= ld_data;
                        if (ld_sel && (32'(ld_addr) < FLEN))
                            fbuf_q[FAW'(ld_addr)] <= ld_data;
                    end
                    if (start) state_q <= RUN;
                end
                RUN: begin
                    if (all_done) state_q <= DONE;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            if (y_fire) ybuf_q[YAW'(y_cnt_q)] <= s_data_y;
            rd_data_q <= (32'(rd_addr) < YLEN) ? ybuf_q[YAW'(rd_addr)] : '0;
        end
    end

endmodule

// File: tb/tb_conv_8_4_host.sv
// Directed bench for conv_8_4_host: reset state, streaming, y capture, readback, mid-run reset.
module tb_conv_8_4_host;

    logic               clk = 1'b0;
    logic               reset, ld_en, ld_sel, start;
    logic [2:0]         ld_addr, rd_addr;
    logic signed [7:0]  ld_data, m_data_x, m_data_f;
    logic               m_valid_x, m_ready_x, m_valid_f, m_ready_f;
    logic signed [17:0] s_data_y, rd_data;
    logic               s_valid_y, s_ready_y, busy, done;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0] addr;
        int         exp_rst;
        int         exp_run;
    } rd_vec_t;

    rd_vec_t rtbl [8];
    int xv  [8] = '{10, -20, 30, -40, 50, 60, 70, 80};
    int fv  [4] = '{10, 20, -30, 40};
    int yv  [5] = '{-2800, 3600, 400, 1600, 2800};
    int yv2 [5] = '{111, -222, 333, -444, 555};

    conv_8_4_host dut (
        .clk(clk), .reset(reset), .ld_en(ld_en), .ld_sel(ld_sel), .ld_addr(ld_addr),
        .ld_data(ld_data), .start(start),
        .m_data_x(m_data_x), .m_valid_x(m_valid_x), .m_ready_x(m_ready_x),
        .m_data_f(m_data_f), .m_valid_f(m_valid_f), .m_ready_f(m_ready_f),
        .s_data_y(s_data_y), .s_valid_y(s_valid_y), .s_ready_y(s_ready_y),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic load(input logic sel, input logic [2:0] addr, input int data);
        ld_en = 1'b1; ld_sel = sel; ld_addr = addr; ld_data = 8'(data);
        tick();
        ld_en = 1'b0;
    endtask

    task automatic load_all();
        for (int i = 0; i < 8; i++) load(1'b0, 3'(i), xv[i]);
        for (int i = 0; i < 4; i++) load(1'b1, 3'(i), fv[i]);
        load(1'b1, 3'd5, 77);
    endtask

    task automatic idle_outputs(input string tag);
        check({tag, "_valid_x"}, int'(m_valid_x), 0);
        check({tag, "_valid_f"}, int'(m_valid_f), 0);
        check({tag, "_ready_y"}, int'(s_ready_y), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
    endtask

    initial begin
        int k, xi, fi, yi, cyc;
        for (int i = 0; i < 8; i++) begin
            rtbl[i].addr    = 3'(i);
            rtbl[i].exp_rst = 0;
            rtbl[i].exp_run = (i < 5) ? yv[i] : 0;
        end
        reset = 1'b1; ld_en = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0; start = 1'b0;
        m_ready_x = 1'b0; m_ready_f = 1'b0; s_data_y = '0; s_valid_y = 1'b0; rd_addr = '0;
        tick(); tick();
        reset = 1'b0;

        // Reset then idle
        repeat (10) tick();
        idle_outputs("rst");
        for (int i = 0; i < 8; i++) begin
            rd_addr = rtbl[i].addr;
            tick();
            check($sformatf("rst_rd%0d", i), int'(rd_data), rtbl[i].exp_rst);
        end

        // Full-rate streaming
        load_all();
        m_ready_x = 1'b1; m_ready_f = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("fr_vx%0d", i), int'(m_valid_x), 1);
            check($sformatf("fr_dx%0d", i), int'(m_data_x), xv[i]);
            check($sformatf("fr_vf%0d", i), int'(m_valid_f), int'(i < 4));
            if (i < 4) check($sformatf("fr_df%0d", i), int'(m_data_f), fv[i]);
            tick();
        end
        check("fr_vx_end", int'(m_valid_x), 0);
        check("fr_vf_end", int'(m_valid_f), 0);
        check("fr_busy", int'(busy), 1);

        // y returned with random valid
        k = 0; cyc = 0;
        while (k < 5 && cyc < 100) begin
            s_valid_y = 1'($urandom_range(0, 1));
            s_data_y  = 18'(yv[k]);
            check("y_ready", int'(s_ready_y), 1);
            check("y_done_early", int'(done), 0);
            tick();
            if (s_valid_y) k++;
            cyc++;
        end
        s_valid_y = 1'b0;
        check("y_count", k, 5);
        check("y_ready_end", int'(s_ready_y), 0);
        check("y_done", int'(done), 1);
        tick();
        check("y_done_clr", int'(done), 0);
        check("y_busy_clr", int'(busy), 0);
        for (int i = 0; i < 8; i++) begin
            rd_addr = rtbl[i].addr;
            tick();
            check($sformatf("run_rd%0d", i), int'(rd_data), rtbl[i].exp_run);
        end

        // Random backpressure with start/ld_en pulsed mid-run
        xi = 0; fi = 0; yi = 0; cyc = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        while ((xi < 8 || fi < 4 || yi < 5) && cyc < 400) begin
            check("rb_vx", int'(m_valid_x), int'(xi < 8));
            if (xi < 8) check("rb_dx", int'(m_data_x), xv[xi]);
            check("rb_vf", int'(m_valid_f), int'(fi < 4));
            if (fi < 4) check("rb_df", int'(m_data_f), fv[fi]);
            check("rb_ry", int'(s_ready_y), int'(yi < 5));
            check("rb_busy", int'(busy), 1);
            check("rb_done", int'(done), 0);
            m_ready_x = 1'($urandom_range(0, 1));
            m_ready_f = 1'($urandom_range(0, 1));
            s_valid_y = 1'($urandom_range(0, 1));
            s_data_y  = (yi < 5) ? 18'(yv2[yi]) : '0;
            if (cyc == 3) begin
                start = 1'b1; ld_en = 1'b1; ld_sel = 1'b0; ld_addr = 3'd0; ld_data = 8'sd99;
            end
            tick();
            start = 1'b0; ld_en = 1'b0;
            if (m_ready_x && xi < 8) xi++;
            if (m_ready_f && fi < 4) fi++;
            if (s_valid_y && yi < 5) yi++;
            cyc++;
        end
        s_valid_y = 1'b0;
        check("rb_complete", int'(xi == 8 && fi == 4 && yi == 5), 1);
        check("rb_done_end", int'(done), 1);
        tick();
        check("rb_idle", int'(busy), 0);
        for (int i = 0; i < 5; i++) begin
            rd_addr = 3'(i);
            tick();
            check($sformatf("rb_rd%0d", i), int'(rd_data), yv2[i]);
        end

        // Reset after 3 x transfers
        m_ready_x = 1'b1; m_ready_f = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        check("mr_dx3", int'(m_data_x), xv[3]);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle_outputs("mr");
        rd_addr = 3'd1;
        tick();
        check("mr_rd1", int'(rd_data), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mr_nodone", int'(done), 0);
        end
        load_all();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("rp_dx%0d", i), int'(m_data_x), xv[i]);
            tick();
        end
        check("rp_vx_end", int'(m_valid_x), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
